sega_decrypt_ctrl: RTL and testbench
====================================

SEGA_DECRYPT_CTRL -- requirements
Module: sega_decrypt_ctrl

Interface
REQ-001 SHALL have parameter AW, default 15: CPU/ROM byte address width, legal range 13..16.
REQ-002 SHALL have parameter TSW, default 2: table-select width.
REQ-003 SHALL have ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  read request, sampled only in IDLE.
- cpu_m1  in  1  1 = opcode fetch, 0 = data read.
- cpu_addr  in  AW  read address.
- cpu_data  out  8  decrypted byte, valid while cpu_ack=1 and held afterwards.
- cpu_ack  out  1  one-cycle completion pulse.
- enc_enable  in  1  1 = decrypt, 0 = pass ROM byte unmodified.
- enc_sel  in  TSW  table select.
- rom_req  out  1  ROM read strobe.
- rom_addr  out  AW  ROM address.
- rom_ack  in  1  rom_data valid this cycle; latency unbounded.
- rom_data  in  8  ROM byte.
- tbl_addr  out  7  decode-table index.
- tbl_sel  out  TSW  equals enc_sel, combinational.
- tbl_data  in  8  table byte, valid one cycle after tbl_addr (registered table).

Function
REQ-004 SHALL implement FSM states IDLE, FETCH, LOOKUP, TBL, plus HIT when SEGA_DECRYPT_CACHE_EN is defined.
REQ-005 IDLE with cpu_req=1 SHALL latch cpu_addr and cpu_m1, then go to FETCH.
REQ-006 FETCH SHALL hold rom_req=1 and rom_addr=latched address until rom_ack=1, latch rom_data, then go to LOOKUP.
REQ-007 LOOKUP SHALL drive tbl_addr = {a[12], a[8], a[4], a[0], ~m1, d[5]^d[7], d[3]^d[7]}, where a is the latched address and d the latched ROM byte; next state TBL.
REQ-008 TBL SHALL compute the result r and register it into cpu_data:
- f = d[7]
- r = (d AND 0x57) OR (tbl_data XOR {f,0,f,0,f,0,0,0})
REQ-009 When enc_enable=0, TBL SHALL use r = d unmodified.
REQ-010 The cycle after TBL SHALL assert cpu_ack=1 for exactly one cycle, with the FSM back in IDLE.
REQ-011 Minimum latency SHALL be:
- cpu_req sampled at cycle N, rom_ack in the first FETCH cycle -> cpu_ack at N+4.
- Each extra rom_ack wait cycle adds one cycle.
REQ-012 cpu_req outside IDLE SHALL be ignored, with no queuing.
REQ-013 A request in the same cycle as cpu_ack (FSM in IDLE) SHALL be accepted.
REQ-014 rom_req SHALL be 0 in every state except FETCH; tbl_addr SHALL hold its last value outside LOOKUP.
REQ-015 enc_enable and enc_sel SHALL be sampled in TBL only; a mid-transaction change affects only later transactions.
REQ-016 Address bits above AW-1 SHALL be treated as 0 when forming tbl_addr.

Reset
REQ-017 reset_n=0 SHALL asynchronously force all of the following, aborting any transaction with no ack:
- state IDLE
- rom_req=0, cpu_ack=0
- cpu_data=0x00, rom_addr=0, tbl_addr=0
- cache invalid
REQ-018 The first request SHALL be accepted on the first rising edge with reset_n=1.

Configuration
REQ-019 With macro SEGA_DECRYPT_CACHE_EN defined, the block SHALL keep a one-entry cache holding tag {m1, addr}, the result byte, and a valid bit.
REQ-020 The cache entry SHALL be written in TBL.
REQ-021 In IDLE, cpu_req with a matching valid tag SHALL go to HIT with no ROM access, giving cpu_ack at N+2 with the cached byte.
REQ-022 The cache SHALL be invalidated on any cycle where enc_enable or enc_sel differs from its previous-cycle value.
REQ-023 Without SEGA_DECRYPT_CACHE_EN, the HIT state and cache registers SHALL be absent and every request SHALL access ROM.

Verification
REQ-024 Decrypt case: enc_enable=1, m1=1, addr=0x1111, rom_data=0xA8, rom_ack at first FETCH cycle -> tbl_addr=0x78, bench tbl_data=0x20 -> cpu_data=0x88, cpu_ack at N+4.
REQ-025 Opcode/data split: same as REQ-024 with m1=0 -> tbl_addr=0x7C; with enc_enable=0 -> cpu_data=0xA8.
REQ-026 ROM wait: rom_ack delayed 5 cycles -> rom_req held stable for 6 cycles, cpu_ack at N+9; cpu_req pulses while busy are ignored.
REQ-027 Reset mid-transaction: reset_n low during FETCH -> rom_req=0 immediately, no cpu_ack, cpu_data=0x00; next request completes normally.
REQ-028 Cache (macro defined): two identical requests -> second acks at N+2 with no rom_req; toggling enc_sel between them -> second takes the full path.

Source files
------------

// File: rtl/sega_decrypt_ctrl_if.sv
// Bus bundle for the Sega opcode/data decryption controller.
// Groups the CPU read port, the ROM read port, the decode-table port and the
// decrypt configuration. The environment (CPU, ROM, table, config) uses the
// master modport, and the controller uses the slave modport.
//
// Handshakes:
//   CPU side : cpu_req is sampled only while the controller is idle. It is
//              not a level-held request, and a request raised while busy is
//              dropped. cpu_ack is a one-cycle completion pulse. cpu_data is
//              valid with it and stays held until the next completion.
//   ROM side : rom_req/rom_addr stay stable until the ROM returns rom_ack=1
//              with rom_data valid in that same cycle. There is no bound on
//              the ROM latency.
//   Table    : registered lookup. tbl_data is valid one cycle after tbl_addr.
interface sega_decrypt_ctrl_if #(
  parameter int AW  = 15,
  parameter int TSW = 2
);
  logic           cpu_req;
  logic           cpu_m1;
  logic [AW-1:0]  cpu_addr;
  logic [7:0]     cpu_data;
  logic           cpu_ack;
  logic           enc_enable;
  logic [TSW-1:0] enc_sel;
  logic           rom_req;
  logic [AW-1:0]  rom_addr;
  logic           rom_ack;
  logic [7:0]     rom_data;
  logic [6:0]     tbl_addr;
  logic [TSW-1:0] tbl_sel;
  logic [7:0]     tbl_data;

  modport master (
    output cpu_req, cpu_m1, cpu_addr, enc_enable, enc_sel,
    output rom_ack, rom_data, tbl_data,
    input  cpu_data, cpu_ack, rom_req, rom_addr, tbl_addr, tbl_sel
  );

  modport slave (
    input  cpu_req, cpu_m1, cpu_addr, enc_enable, enc_sel,
    input  rom_ack, rom_data, tbl_data,
    output cpu_data, cpu_ack, rom_req, rom_addr, tbl_addr, tbl_sel
  );
endinterface

// File: rtl/sega_decrypt_ctrl.sv
// Sega-style ROM decryption controller.
// A CPU read fetches one byte from ROM. The controller forms a decode-table
// index from the address, the opcode/data flag and two ROM-byte parities. It
// then merges the registered table output with the untouched ROM bits and
// returns the result with a one-cycle ack.
// Optional feature macro: SEGA_DECRYPT_CACHE_EN adds a one-entry result cache
// (HIT state) that answers a repeated {m1, addr} read without a ROM access.
// dbg_state exposes the FSM state for checkers.
module sega_decrypt_ctrl #(
  parameter int AW  = 15,
  parameter int TSW = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sega_decrypt_ctrl_if.slave   bus,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOOKUP = 3'd2,
`ifdef SEGA_DECRYPT_CACHE_EN
    S_TBL    = 3'd3,
    S_HIT    = 3'd4
`else
    S_TBL    = 3'd3
`endif
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Latched request attributes. rom_addr doubles as the latched CPU address.
  logic        m1_q;
  logic [7:0]  rom_byte_q;

  logic [6:0]  tbl_idx_nxt;
  logic [7:0]  flip_mask;
  logic [7:0]  result;

  // The table is a plain pass-through of the select, and the ROM strobe is
  // decoded straight from state, so reset drops it immediately.
  assign bus.tbl_sel = bus.enc_sel;
  assign bus.rom_req = (state == S_FETCH);
  assign dbg_state   = state;

  // Table index. It is formed from the incoming ROM byte so that the
  // registered index is valid during LOOKUP. AW is at least 13, so address
  // bit 12 always exists and higher bits never take part.
  always_comb begin
    tbl_idx_nxt = {bus.rom_addr[12], bus.rom_addr[8], bus.rom_addr[4],
                   bus.rom_addr[0], ~m1_q,
                   bus.rom_data[5] ^ bus.rom_data[7],
                   bus.rom_data[3] ^ bus.rom_data[7]};
  end

  // Decrypted byte. Bits 0,1,2,4,6 come through from ROM, and the others come
  // from the table, with ROM bit 7 inverting table bits 3, 5 and 7.
  always_comb begin
    flip_mask = {rom_byte_q[7], 1'b0, rom_byte_q[7], 1'b0, rom_byte_q[7], 3'b000};
    if (bus.enc_enable) begin
      result = (rom_byte_q & 8'h57) | (bus.tbl_data ^ flip_mask);
    end else begin
      result = rom_byte_q;
    end
  end

`ifdef SEGA_DECRYPT_CACHE_EN
  logic           cache_vld;
  logic [AW:0]    cache_tag;
  logic [7:0]     cache_byte;
  logic           prev_en;
  logic [TSW-1:0] prev_sel;
  logic           cfg_chg;
  logic           hit;

  // A config change in this cycle makes any cached byte stale, including for
  // a lookup made in the same cycle.
  assign cfg_chg = (bus.enc_enable != prev_en) || (bus.enc_sel != prev_sel);
  assign hit     = cache_vld && !cfg_chg && (cache_tag == {bus.cpu_m1, bus.cpu_addr});

  // Cache entry: filled when a full lookup completes, dropped on config change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cache_vld  <= 1'b0;
      cache_tag  <= '0;
      cache_byte <= 8'h00;
      prev_en    <= 1'b0;
      prev_sel   <= '0;
    end else begin
      prev_en  <= bus.enc_enable;
      prev_sel <= bus.enc_sel;
      if (cfg_chg) begin
        cache_vld <= 1'b0;
      end else if (state == S_TBL) begin
        cache_vld  <= 1'b1;
        cache_tag  <= {m1_q, bus.rom_addr};
        cache_byte <= result;
      end
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. Requests outside IDLE are simply not looked at.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.cpu_req) begin
`ifdef SEGA_DECRYPT_CACHE_EN
          state_nxt = hit ? S_HIT : S_FETCH;
`else
          state_nxt = S_FETCH;
`endif
        end
      end
      S_FETCH: begin
        if (bus.rom_ack) begin
          state_nxt = S_LOOKUP;
        end
      end
      S_LOOKUP: state_nxt = S_TBL;
      S_TBL:    state_nxt = S_IDLE;
`ifdef SEGA_DECRYPT_CACHE_EN
      S_HIT:    state_nxt = S_IDLE;
`endif
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Datapath: latch the request and the ROM byte, register the table index,
  // and produce the result with its ack pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.rom_addr <= '0;
      m1_q         <= 1'b0;
      rom_byte_q   <= 8'h00;
      bus.tbl_addr <= 7'h00;
      bus.cpu_data <= 8'h00;
      bus.cpu_ack  <= 1'b0;
    end else begin
      bus.cpu_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.cpu_req) begin
            bus.rom_addr <= bus.cpu_addr;
            m1_q         <= bus.cpu_m1;
          end
        end
        S_FETCH: begin
          if (bus.rom_ack) begin
            rom_byte_q   <= bus.rom_data;
            bus.tbl_addr <= tbl_idx_nxt;
          end
        end
        S_TBL: begin
          bus.cpu_data <= result;
          bus.cpu_ack  <= 1'b1;
        end
`ifdef SEGA_DECRYPT_CACHE_EN
        S_HIT: begin
          bus.cpu_data <= cache_byte;
          bus.cpu_ack  <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sega_decrypt_ctrl.sv
// Testbench for sega_decrypt_ctrl: directed decrypt/split/wait/reset steps
// followed by randomized reads, all checked against a reference model.
module tb_sega_decrypt_ctrl;
  localparam int AW  = 15;
  localparam int TSW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  sega_decrypt_ctrl_if #(.AW(AW), .TSW(TSW)) bus ();

  sega_decrypt_ctrl #(.AW(AW), .TSW(TSW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- external memories ----------------
  logic [7:0] rom_mem [0:(1<<AW)-1];
  logic [7:0] tbl_mem [0:(1<<TSW)-1][0:127];

  // Registered decode table: data follows the index by one clock.
  always @(posedge clk) bus.tbl_data <= tbl_mem[bus.tbl_sel][bus.tbl_addr];

  // ---------------- scoreboard state ----------------
  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  bit          m_vld;
  logic        m_m1;
  logic [AW-1:0] m_addr;
  logic [7:0]  m_byte;
  logic [7:0]  prev_data;
  int          last_lat;
  logic [7:0]  last_data;
  logic [6:0]  last_tbl;
  logic [AW-1:0] pool [0:3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: table index built from the address/flag/byte rules.
  function automatic logic [6:0] ref_index(input logic [AW-1:0] a, input logic m1,
                                           input logic [7:0] d);
    int ai;
    int v;
    ai = int'(a);
    v = ((ai >> 12) & 1) * 64 + ((ai >> 8) & 1) * 32 + ((ai >> 4) & 1) * 16 +
        (ai & 1) * 8 + (m1 ? 0 : 4) + ((d[5] != d[7]) ? 2 : 0) +
        ((d[3] != d[7]) ? 1 : 0);
    return v[6:0];
  endfunction

  function automatic logic [7:0] ref_byte(input logic [AW-1:0] a, input logic m1,
                                          input logic en, input logic [TSW-1:0] sel);
    logic [7:0] d;
    logic [7:0] t;
    d = rom_mem[a];
    if (!en) return d;
    t = tbl_mem[sel][ref_index(a, m1, d)];
    return (d & 8'h57) | (t ^ (d[7] ? 8'hA8 : 8'h00));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_cfg(input logic en, input logic [TSW-1:0] sel);
    if (en !== bus.enc_enable || sel !== bus.enc_sel) m_vld = 0;
    bus.enc_enable = en;
    bus.enc_sel    = sel;
  endtask

  // Starts a request at the current negedge and returns at the negedge where
  // the ack is seen, so back-to-back calls request in the ack cycle.
  task automatic read_txn(input logic m1, input logic [AW-1:0] addr,
                          input int waits, input bit pulses);
    bit         exp_hit;
    int         exp_lat;
    int         k;
    int         rc;
    bit         got;
    logic [7:0] d;
    logic [6:0] exp_idx;
    logic [7:0] exp_data;
    d        = rom_mem[addr];
    exp_idx  = ref_index(addr, m1, d);
    exp_data = ref_byte(addr, m1, bus.enc_enable, bus.enc_sel);
    exp_hit  = 0;
`ifdef SEGA_DECRYPT_CACHE_EN
    exp_hit  = m_vld && (m_m1 == m1) && (m_addr == addr);
`endif
    if (exp_hit) exp_data = m_byte;
    exp_lat = exp_hit ? 2 : 4 + waits;
    exp_q.push_back(exp_data);

    bus.cpu_req  = 1'b1;
    bus.cpu_m1   = m1;
    bus.cpu_addr = addr;
    k = 0; rc = 0; got = 0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        check("ack_single_cycle", bus.cpu_ack, 1'b0);
        check("data_held", bus.cpu_data, prev_data);
      end
      bus.cpu_req = 1'b0;
      if (pulses) begin
        bus.cpu_req  = 1'($urandom_range(0, 1));
        bus.cpu_m1   = 1'($urandom_range(0, 1));
        bus.cpu_addr = AW'($urandom_range(0, (1 << AW) - 1));
      end
      if (bus.rom_req) begin
        rc++;
        check("rom_addr_stable", bus.rom_addr, addr);
      end
      if (bus.rom_req && rc == waits + 1) begin
        bus.rom_ack  = 1'b1;
        bus.rom_data = d;
      end else begin
        bus.rom_ack  = 1'b0;
        bus.rom_data = 8'($urandom_range(0, 255));
      end
      if (bus.cpu_ack) begin
        got = 1;
        bus.cpu_req = 1'b0;
        bus.rom_ack = 1'b0;
      end
    end
    check("ack_seen", got, 1'b1);
    check("latency", k, exp_lat);
    check("cpu_data", bus.cpu_data, exp_q.pop_front());
    check("rom_cycles", rc, exp_hit ? 0 : waits + 1);
    if (!exp_hit) check("tbl_addr", bus.tbl_addr, exp_idx);
    check("tbl_sel", bus.tbl_sel, bus.enc_sel);
    last_lat  = k;
    last_data = bus.cpu_data;
    last_tbl  = bus.tbl_addr;
    prev_data = exp_data;
    if (!exp_hit) begin
      m_vld  = 1;
      m_m1   = m1;
      m_addr = addr;
      m_byte = exp_data;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n        = 1'b0;
    bus.cpu_req    = 1'b0;
    bus.cpu_m1     = 1'b0;
    bus.cpu_addr   = '0;
    bus.rom_ack    = 1'b0;
    bus.rom_data   = 8'h00;
    bus.enc_enable = 1'b1;
    bus.enc_sel    = '0;
    m_vld = 0; m_m1 = 0; m_addr = '0; m_byte = 8'h00; prev_data = 8'h00;
    for (int i = 0; i < (1 << AW); i++) rom_mem[i] = 8'($urandom_range(0, 255));
    for (int s = 0; s < (1 << TSW); s++)
      for (int j = 0; j < 128; j++) tbl_mem[s][j] = 8'($urandom_range(0, 255));
    for (int p = 0; p < 4; p++) pool[p] = AW'($urandom_range(0, (1 << AW) - 1));
    rom_mem[15'h1111] = 8'hA8;
    tbl_mem[0][7'h78] = 8'h20;

    repeat (3) @(negedge clk);
    check("rst_rom_req", bus.rom_req, 1'b0);
    check("rst_cpu_ack", bus.cpu_ack, 1'b0);
    check("rst_cpu_data", bus.cpu_data, 8'h00);
    check("rst_rom_addr", bus.rom_addr, 15'h0);
    check("rst_tbl_addr", bus.tbl_addr, 7'h00);
    check("rst_state_idle", dbg_state, 3'd0);
    reset_n = 1'b1;

    // Decrypt case for an opcode fetch.
    read_txn(1'b1, 15'h1111, 0, 0);
    check("dec_data", last_data, 8'h88);
    check("dec_tbl", last_tbl, 7'h78);
    check("dec_lat", last_lat, 4);

    // Data read of the same address uses the other table half.
    read_txn(1'b0, 15'h1111, 0, 0);
    check("data_tbl", last_tbl, 7'h7C);

    // Pass-through mode.
    set_cfg(1'b0, 2'd0);
    read_txn(1'b1, 15'h1111, 0, 0);
    check("bypass_data", last_data, 8'hA8);

    // ROM wait states with ignored requests while busy.
    set_cfg(1'b1, 2'd1);
    read_txn(1'b1, 15'h0333, 5, 1);
    check("wait_lat", last_lat, 9);

    // Repeated request, then a table-select change between repeats.
    read_txn(1'b1, 15'h0444, 1, 0);
    read_txn(1'b1, 15'h0444, 1, 0);
    set_cfg(1'b1, 2'd2);
    read_txn(1'b1, 15'h0444, 1, 0);
    check("sel_change_full", last_lat, 5);

    // Reset while the ROM is still being waited on.
    bus.cpu_req  = 1'b1;
    bus.cpu_m1   = 1'b1;
    bus.cpu_addr = 15'h0222;
    bus.rom_ack  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      bus.cpu_req = 1'b0;
    end
    check("pre_rst_rom_req", bus.rom_req, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_rom_req", bus.rom_req, 1'b0);
    check("mid_rst_cpu_ack", bus.cpu_ack, 1'b0);
    check("mid_rst_cpu_data", bus.cpu_data, 8'h00);
    check("mid_rst_rom_addr", bus.rom_addr, 15'h0);
    check("mid_rst_tbl_addr", bus.tbl_addr, 7'h00);
    @(negedge clk);
    check("mid_rst_no_ack", bus.cpu_ack, 1'b0);
    reset_n   = 1'b1;
    m_vld     = 0;
    prev_data = 8'h00;
    read_txn(1'b1, 15'h0222, 0, 0);

    // Randomized reads over a small address pool, so repeats occur.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0)
        set_cfg(1'($urandom_range(0, 1)), TSW'($urandom_range(0, (1 << TSW) - 1)));
      read_txn(1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)],
               $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    bus.cpu_req = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
